// File: rtl/morse_seq_module_pkg.sv
// Typed constants and sizing helpers for the Morse sequencer, built on morse_defs.vh.
`ifndef MORSE_DEFS_VH
`include "morse_defs.vh"
`endif

package morse_seq_module_pkg;

    typedef logic [1:0] sym_t;
    typedef logic [2:0] state_t;

    localparam sym_t SYM_END  = `SYM_END;
    localparam sym_t SYM_DOT  = `SYM_DOT;
    localparam sym_t SYM_DASH = `SYM_DASH;
    localparam sym_t SYM_GAP  = `SYM_GAP;

    localparam state_t ST_IDLE  = `ST_IDLE;
    localparam state_t ST_LOAD  = `ST_LOAD;
    localparam state_t ST_MARK  = `ST_MARK;
    localparam state_t ST_SPACE = `ST_SPACE;
    localparam state_t ST_FIN   = `ST_FIN;

    function automatic int max_units(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Unit counter never narrower than 3 bits, widened only for long elements.
    function automatic int unit_cnt_width(input int max_u);
        return (max_u > 7) ? $clog2(max_u + 1) : 3;
    endfunction

endpackage

// File: rtl/morse_defs.vh
// Symbol codes and FSM state encodings shared by the Morse sequencer files.
`ifndef MORSE_DEFS_VH
`define MORSE_DEFS_VH

`define SYM_END   2'b00
`define SYM_DOT   2'b01
`define SYM_DASH  2'b10
`define SYM_GAP   2'b11

`define ST_IDLE   3'd0
`define ST_LOAD   3'd1
`define ST_MARK   3'd2
`define ST_SPACE  3'd3
`define ST_FIN    3'd4

`endif

// File: rtl/morse_seq_module_unit_tick.sv
// Cycle/unit timebase: cycle counter wraps every T_UNIT clocks, unit counter counts wraps.
module unit_tick_module #(
    parameter int T_UNIT = 25_000_000,
    parameter int UNIT_W = 3
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              Clr,
    output logic              Unit_Tick,
    output logic [UNIT_W-1:0] Unit_Cnt
);

    localparam int CW = $clog2(T_UNIT);

    logic [CW-1:0] cyc;

    assign Unit_Tick = (cyc == CW'(T_UNIT - 1));

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cyc      <= '0;
            Unit_Cnt <= '0;
        end else if (Clr) begin
            cyc      <= '0;
            Unit_Cnt <= '0;
        end else if (Unit_Tick) begin
            cyc      <= '0;
            Unit_Cnt <= Unit_Cnt + UNIT_W'(1);
        end else begin
            cyc <= cyc + CW'(1);
        end
    end

endmodule

// File: rtl/morse_seq_module.sv
// Morse playback sequencer: plays packed DOT/DASH/GAP symbols on Pin_Out.
// Optional MORSE_REPEAT_EN adds a Repeat input that loops the message.
module morse_seq_module
    import morse_seq_module_pkg::*;
#(
    parameter int T_UNIT      = 25_000_000,
    parameter int DEPTH       = 16,
    parameter int DOT_UNITS   = 2,
    parameter int DASH_UNITS  = 6,
    parameter int SPACE_UNITS = 1,
    parameter int GAP_UNITS   = 3
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               Start,
    input  logic               Abort,
    input  logic [2*DEPTH-1:0] Msg,
`ifdef MORSE_REPEAT_EN
    input  logic               Repeat,
`endif
    output logic               Pin_Out,
    output logic               Busy,
    output logic               Done
);

    localparam int UNIT_W = unit_cnt_width(max_units(DOT_UNITS, DASH_UNITS, SPACE_UNITS, GAP_UNITS));
    localparam int IDX_W  = $clog2(DEPTH + 1);

    state_t             state, nxt;
    logic [2*DEPTH-1:0] shreg, shreg_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [UNIT_W-1:0]  units, units_nxt;
    logic [UNIT_W-1:0]  unit_cnt;
    logic               unit_tick;
    logic               clr;
    logic               expire;
    logic               load_sym;
    sym_t               sym;
`ifdef MORSE_REPEAT_EN
    logic [2*DEPTH-1:0] msg_copy;
    logic               rewind, rewind_nxt;
`endif

    unit_tick_module #(
        .T_UNIT (T_UNIT),
        .UNIT_W (UNIT_W)
    ) u_tick (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .Clr       (clr),
        .Unit_Tick (unit_tick),
        .Unit_Cnt  (unit_cnt)
    );

    // Last cycle of the current element's final unit.
    assign expire = unit_tick && (unit_cnt == units - UNIT_W'(1));

    always_comb begin
        nxt       = state;
        shreg_nxt = shreg;
        idx_nxt   = idx;
        units_nxt = units;
        load_sym  = 1'b0;
        sym       = shreg[1:0];
`ifdef MORSE_REPEAT_EN
        rewind_nxt = rewind;
`endif
        case (state)
            ST_IDLE: begin
                if (Start && !Abort) begin
                    nxt       = ST_LOAD;
                    shreg_nxt = Msg;
                    idx_nxt   = '0;
                end
            end
            ST_LOAD: load_sym = 1'b1;
            ST_MARK: begin
                if (expire) begin
                    nxt       = ST_SPACE;
                    units_nxt = UNIT_W'(SPACE_UNITS);
                end
            end
            ST_SPACE: begin
                if (expire) begin
                    load_sym = 1'b1;
`ifdef MORSE_REPEAT_EN
                    if (rewind) begin
                        shreg_nxt  = msg_copy;
                        idx_nxt    = '0;
                        sym        = msg_copy[1:0];
                        rewind_nxt = 1'b0;
                    end else begin
                        shreg_nxt = shreg >> 2;
                        idx_nxt   = idx + IDX_W'(1);
                        sym       = shreg[3:2];
                    end
`else
                    shreg_nxt = shreg >> 2;
                    idx_nxt   = idx + IDX_W'(1);
                    sym       = shreg[3:2];
`endif
                end
            end
            ST_FIN: begin
`ifdef MORSE_REPEAT_EN
                if (Repeat) begin
                    nxt        = ST_SPACE;
                    units_nxt  = UNIT_W'(GAP_UNITS);
                    rewind_nxt = 1'b1;
                end else begin
                    nxt = ST_IDLE;
                end
`else
                nxt = ST_IDLE;
`endif
            end
            default: nxt = ST_IDLE;
        endcase

        if (load_sym) begin
            if (idx_nxt == IDX_W'(DEPTH)) begin
                nxt = ST_FIN;
            end else begin
                case (sym)
                    SYM_DOT:  begin nxt = ST_MARK;  units_nxt = UNIT_W'(DOT_UNITS);  end
                    SYM_DASH: begin nxt = ST_MARK;  units_nxt = UNIT_W'(DASH_UNITS); end
                    SYM_GAP:  begin nxt = ST_SPACE; units_nxt = UNIT_W'(GAP_UNITS);  end
                    default:  nxt = ST_FIN;
                endcase
            end
        end

        if (state != ST_IDLE && Abort) nxt = ST_IDLE;

        // Every element entry (including SPACE->SPACE) starts on a fresh unit.
        clr = (nxt != state) || expire;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            idx     <= '0;
            units   <= '0;
            Pin_Out <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state   <= nxt;
            shreg   <= shreg_nxt;
            idx     <= idx_nxt;
            units   <= units_nxt;
            Pin_Out <= (nxt == ST_MARK);
            Busy    <= (nxt != ST_IDLE);
            Done    <= (nxt == ST_FIN);
        end
    end

`ifdef MORSE_REPEAT_EN
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            msg_copy <= '0;
            rewind   <= 1'b0;
        end else begin
            if (state == ST_IDLE && nxt == ST_LOAD) msg_copy <= Msg;
            rewind <= (nxt == ST_IDLE) ? 1'b0 : rewind_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_morse_seq_module.sv
// Directed self-checking bench for morse_seq_module with T_UNIT=4.
module tb_morse_seq_module;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic [31:0] Msg = '0;
`ifdef MORSE_REPEAT_EN
    logic        Repeat = 1'b0;
`endif
    logic        Pin_Out, Busy, Done;

    int n_checks = 0;
    int n_pass   = 0;

    morse_seq_module #(.T_UNIT(4), .DEPTH(16)) dut (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .Start   (Start),
        .Abort   (Abort),
        .Msg     (Msg),
`ifdef MORSE_REPEAT_EN
        .Repeat  (Repeat),
`endif
        .Pin_Out (Pin_Out),
        .Busy    (Busy),
        .Done    (Done)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // '.'=DOT '-'=DASH '_'=GAP, unlisted positions are END.
    function automatic logic [31:0] enc(input string s);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < s.len(); k++) begin
            case (s[k])
                "." : m[2*k +: 2] = 2'b01;
                "-" : m[2*k +: 2] = 2'b10;
                "_" : m[2*k +: 2] = 2'b11;
                default: m[2*k +: 2] = 2'b00;
            endcase
        end
        return m;
    endfunction

    // n cycles at Pin_Out=lvl with Busy high and no Done.
    task automatic seg(input logic lvl, input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (Pin_Out !== lvl || Busy !== 1'b1 || Done !== 1'b0) bad++;
            step();
        end
        check(tag, bad, 0);
    endtask

    task automatic start_msg(input logic [31:0] m, input string tag);
        Msg   = m;
        Start = 1'b1;
        step();
        Start = 1'b0;
        check({tag, "_load_busy"}, int'(Busy), 1);
        check({tag, "_load_pin"}, int'(Pin_Out), 0);
        step();
    endtask

    task automatic fin(input string tag);
        check({tag, "_done"}, int'(Done), 1);
        check({tag, "_fin_pin"}, int'(Pin_Out), 0);
        step();
        check({tag, "_done_clr"}, int'(Done), 0);
        check({tag, "_busy_clr"}, int'(Busy), 0);
    endtask

    task automatic dot(input string tag);
        seg(1'b1, 8, {tag, "_dot_on"});
        seg(1'b0, 4, {tag, "_dot_off"});
    endtask

    task automatic dash(input string tag);
        seg(1'b1, 24, {tag, "_dash_on"});
        seg(1'b0, 4, {tag, "_dash_off"});
    endtask

    initial begin
        int cnt;

        #12;
        check("rst_pin", int'(Pin_Out), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_done", int'(Done), 0);
        RST_n = 1'b1;
        step();
        step();

        // Single DOT
        start_msg(enc("."), "dot1");
        dot("dot1");
        fin("dot1");

        // Empty message: LOAD then FIN immediately
        Msg = '0;
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("end_busy1", int'(Busy), 1);
        check("end_pin1", int'(Pin_Out), 0);
        step();
        check("end_busy2", int'(Busy), 1);
        fin("end");

        // SOS; Msg altered and Start held during playback must be ignored
        start_msg(enc("..._---_..."), "sos");
        Msg = enc("-");
        dot("sos1"); dot("sos2"); dot("sos3");
        seg(1'b0, 12, "sos_gap1");
        Start = 1'b1;
        dash("sos4");
        Start = 1'b0;
        dash("sos5"); dash("sos6");
        seg(1'b0, 12, "sos_gap2");
        dot("sos7"); dot("sos8"); dot("sos9");
        fin("sos");

        // Abort at cycle 10 of a DASH mark, then replay from symbol 0
        start_msg(enc("-."), "abt");
        seg(1'b1, 10, "abt_mark");
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        check("abt_pin", int'(Pin_Out), 0);
        check("abt_busy", int'(Busy), 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (Done !== 1'b0 || Busy !== 1'b0) cnt++;
            step();
        end
        check("abt_quiet", cnt, 0);
        start_msg(enc("-."), "rep");
        dash("rep1");
        dot("rep2");
        fin("rep");

        // Abort wins over simultaneous Start
        Start = 1'b1;
        Abort = 1'b1;
        step();
        Start = 1'b0;
        Abort = 1'b0;
        check("abt_start_busy", int'(Busy), 0);

        // Full DEPTH of DOTs, no END symbol
        start_msg(32'h5555_5555, "full");
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 12; j++) begin
                if (Pin_Out !== (j < 8) || Busy !== 1'b1 || Done !== 1'b0) cnt++;
                step();
            end
        end
        check("full_marks", cnt, 0);
        fin("full");

        // Asynchronous reset in the middle of a mark
        start_msg(enc("-"), "rst");
        seg(1'b1, 3, "rst_mark");
        RST_n = 1'b0;
        #2;
        check("arst_pin", int'(Pin_Out), 0);
        check("arst_busy", int'(Busy), 0);
        check("arst_done", int'(Done), 0);
        step();
        RST_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (Pin_Out !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) cnt++;
            step();
        end
        check("arst_idle", cnt, 0);
        start_msg(enc("."), "post");
        dot("post");
        fin("post");

`ifdef MORSE_REPEAT_EN
        // Looping playback until Abort
        Repeat = 1'b1;
        start_msg(enc("."), "loop");
        dot("loop1");
        check("loop_done1", int'(Done), 1);
        check("loop_busy1", int'(Busy), 1);
        step();
        seg(1'b0, 12, "loop_gap");
        dot("loop2");
        check("loop_done2", int'(Done), 1);
        step();
        seg(1'b0, 5, "loop_gap2");
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        Repeat = 1'b0;
        check("loop_abort_busy", int'(Busy), 0);
        check("loop_abort_pin", int'(Pin_Out), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/morse_seq_module.md
MORSE_SEQ_MODULE -- requirements
Module: morse_seq_module

Interface
REQ-001 SHALL have parameter T_UNIT, default 25_000_000; clock cycles per time unit (0.5 s at 50 MHz); minimum 2.
REQ-002 SHALL have parameter DEPTH, default 16; maximum symbols per message; range 2..32.
REQ-003 SHALL have parameters DOT_UNITS=2, DASH_UNITS=6, SPACE_UNITS=1, GAP_UNITS=3; each is a duration in units; each is at least 1.
REQ-004 SHALL have port CLK  input  1  system clock, one clock, all logic on the rising edge.
REQ-005 SHALL have port RST_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port Start  input  1  one-cycle request to play Msg.
REQ-007 SHALL have port Abort  input  1  stop playback immediately.
REQ-008 SHALL have port Msg  input  2*DEPTH  packed symbols; symbol k occupies bits [2k+1:2k]; 00=END, 01=DOT, 10=DASH, 11=GAP.
REQ-009 SHALL have port Repeat  input  1  loop the message; present only when MORSE_REPEAT_EN is defined.
REQ-010 SHALL have port Pin_Out  output  1  LED/buzzer drive; 1 = on.
REQ-011 SHALL have port Busy  output  1  high while playback is active.
REQ-012 SHALL have port Done  output  1  one-cycle pulse when playback completes normally.

Function
REQ-013 SHALL implement an FSM with states IDLE, LOAD, MARK, SPACE, FIN.
REQ-014 IDLE: when Start=1 and Abort=0, SHALL go to LOAD on the next edge; while Busy=1, Start SHALL be ignored.
REQ-015 LOAD: SHALL latch Msg into an internal shift register, set index=0 and Busy=1; later Msg changes SHALL have no effect until the next LOAD.
REQ-016 LOAD/decode: DOT SHALL go to MARK for DOT_UNITS; DASH SHALL go to MARK for DASH_UNITS; GAP SHALL go to SPACE with Pin_Out=0 for GAP_UNITS; END, or index==DEPTH, SHALL go to FIN.
REQ-017 MARK: Pin_Out SHALL be 1 for exactly units*T_UNIT cycles, then go to SPACE for SPACE_UNITS with Pin_Out=0.
REQ-018 SPACE expiry: SHALL shift the register by 2, increment index and decode the next symbol with no idle cycle in between.
REQ-019 Unit timing: a cycle counter SHALL count 0..T_UNIT-1; a unit counter SHALL increment on wrap; both SHALL clear on every state entry, so each element starts on a fresh unit.
REQ-020 Counter width SHALL be $clog2(T_UNIT); the unit counter SHALL be 3 bits wide, or wider if any *_UNITS parameter exceeds 7.
REQ-021 FIN: Pin_Out SHALL be 0, Done SHALL be 1 for one cycle, Busy SHALL be 0 from the next cycle, and the FSM SHALL return to IDLE.
REQ-022 Abort=1 in any non-IDLE state SHALL, on the next edge, set Pin_Out=0, Busy=0 and state=IDLE, with no Done pulse; Abort SHALL win over a simultaneous Start.
REQ-023 A message whose symbol 0 is END SHALL go LOAD->FIN: Busy high for 2 cycles, then Done, with Pin_Out never high.
REQ-024 Pin_Out and Done SHALL be registered outputs with no combinational path from any input.

Reset
REQ-025 RST_n=0 SHALL asynchronously force state=IDLE, Pin_Out=0, Busy=0, Done=0, and clear all counters, the shift register and index.
REQ-026 Reset asserted mid-playback SHALL abandon the message; after release the block SHALL wait in IDLE for a new Start.

Configuration
REQ-027 Macro MORSE_REPEAT_EN, when defined, SHALL add the Repeat port: at FIN with Repeat=1, the block SHALL pulse Done, apply GAP_UNITS of off time, then reload from the latched copy with Busy held high.
REQ-028 Without MORSE_REPEAT_EN, there SHALL be no Repeat port and FIN SHALL always return to IDLE.

Structure
REQ-029 A shared include file morse_defs.vh SHALL hold the symbol codes (SYM_END, SYM_DOT, SYM_DASH, SYM_GAP) and the FSM state encodings.
REQ-030 The cycle/unit counting SHALL be a sub-module unit_tick_module (ports CLK, RST_n, Clr, Unit_Tick, Unit_Cnt).

Verification (T_UNIT=4, default unit parameters)
REQ-031 Msg=DOT,END + Start -> Pin_Out high 8 cycles, low 4 cycles, Done pulses once, Busy falls.
REQ-032 Msg=S,O,S (DOT x3, GAP, DASH x3, GAP, DOT x3, END) -> high/low widths 8/4 for dots, 24/4 for dashes, 12 extra low cycles at each GAP, one Done.
REQ-033 Abort mid-DASH (cycle 10 of MARK) -> Pin_Out=0 and Busy=0 next cycle, no Done; a later Start replays from symbol 0.
REQ-034 Start with all DEPTH symbols set to DOT -> exactly 16 marks, then Done without an END symbol.
REQ-035 RST_n pulsed low mid-MARK -> all outputs 0 immediately; Start while Busy and Msg changes during playback -> ignored.
REQ-036 With MORSE_REPEAT_EN and Repeat=1 -> Done per pass, 12-cycle gap, pattern restarts, Busy stays high until Abort.
